infifo_thread_scheduler: RTL and testbench

- Upstream feeder of the input-FIFO arbiter.
- Pops whole packets from the shared first-word-fall-through small input FIFO and assigns each packet to a hardware thread in round-robin order.
- Drives the arbiter's thread_sel / thread_sel_next / firstword / fifowrite / enable_cpu strobes with per-packet data.
- Honours the arbiter's stop_smallfifo_read back-pressure and bounds runaway packets with a word-count limit.

---
 rtl/infifo_thread_scheduler.sv | 124 ++++++++++++
 tb/tb_infifo_thread_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/infifo_thread_scheduler.sv
// Input-FIFO thread scheduler: pops whole packets from the FWFT small FIFO
// and hands each one to the next hardware thread in round-robin order.
module infifo_thread_scheduler #(
    parameter int NUM_THREADS = 4,
    parameter int THREAD_BITS = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int MAX_WORDS   = 256,
    parameter bit SKIP_BUSY   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_fifo_empty,
    input  logic [DATA_WIDTH-1:0]  in_fifo_data,
    input  logic                   in_fifo_sof,
    input  logic                   in_fifo_eof,
    output logic                   in_fifo_rd_en,
    input  logic                   stop_smallfifo_read,
    output logic [THREAD_BITS-1:0] thread_sel,
    output logic [THREAD_BITS-1:0] thread_sel_next,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   firstword_out,
    output logic                   fifowrite_out,
    output logic                   out_last,
    output logic                   enable_cpu_out,
    output logic                   pkt_trunc,
    output logic [15:0]            drop_cnt
);

    typedef enum logic [1:0] {IDLE, READ, LAST, ENABLE} state_t;

    localparam logic [15:0] CNT_LAST = 16'(MAX_WORDS - 1);
    localparam logic [THREAD_BITS-1:0] T_ONE = THREAD_BITS'(1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] word_cnt;
    logic        take_first;
    logic        take_word;
    logic        drop_word;
    logic        skip;
    logic        cut;

    always_comb begin
        state_nxt     = state;
        in_fifo_rd_en = 1'b0;
        take_first    = 1'b0;
        take_word     = 1'b0;
        drop_word     = 1'b0;
        skip          = 1'b0;
        cut           = 1'b0;
        unique case (state)
            IDLE: begin
                if (!in_fifo_empty) begin
                    if (!in_fifo_sof) begin
                        in_fifo_rd_en = 1'b1;
                        drop_word     = 1'b1;
                    end else if (stop_smallfifo_read) begin
                        skip = SKIP_BUSY;
                    end else begin
                        in_fifo_rd_en = 1'b1;
                        take_first    = 1'b1;
                        state_nxt     = in_fifo_eof ? LAST : READ;
                    end
                end
            end
            READ: begin
                if (!in_fifo_empty) begin
                    in_fifo_rd_en = 1'b1;
                    take_word     = 1'b1;
                    cut           = !in_fifo_eof && (word_cnt == CNT_LAST);
                    if (in_fifo_eof || cut)
                        state_nxt = LAST;
                end
            end
            LAST:    state_nxt = ENABLE;
            ENABLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // a word popped during reset would be lost, so never pop then
        if (reset)
            in_fifo_rd_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            thread_sel      <= '0;
            thread_sel_next <= '0;
            out_data        <= '0;
            firstword_out   <= 1'b0;
            fifowrite_out   <= 1'b0;
            out_last        <= 1'b0;
            enable_cpu_out  <= 1'b0;
            pkt_trunc       <= 1'b0;
            drop_cnt        <= '0;
            word_cnt        <= '0;
        end else begin
            state          <= state_nxt;
            fifowrite_out  <= take_first | take_word;
            firstword_out  <= take_first;
            out_last       <= 1'b0;
            enable_cpu_out <= (state == LAST);
            if (take_first | take_word) begin
                out_data <= in_fifo_data;
                out_last <= in_fifo_eof | cut;
            end
            if (take_first) begin
                thread_sel <= thread_sel_next;
                word_cnt   <= 16'd1;
            end
            if (take_word)
                word_cnt <= word_cnt + 16'd1;
            if (cut)
                pkt_trunc <= 1'b1;
            if (drop_word && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (skip)
                thread_sel_next <= thread_sel_next + T_ONE;
            if (state == ENABLE)
                thread_sel_next <= thread_sel + T_ONE;
        end
    end

endmodule

// File: tb/tb_infifo_thread_scheduler.sv
// Randomised bench for infifo_thread_scheduler against a packet-level
// reference model with a queue-backed FWFT FIFO source.
module tb_infifo_thread_scheduler;

    localparam int NT   = 4;
    localparam int TBW  = 2;
    localparam int DW   = 64;
    localparam int MAXW = 4;
    localparam bit SKIP = 1'b1;

    typedef struct packed {
        logic          sof;
        logic          eof;
        logic [DW-1:0] data;
    } word_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_fifo_empty;
    logic [DW-1:0]  in_fifo_data;
    logic           in_fifo_sof;
    logic           in_fifo_eof;
    logic           in_fifo_rd_en;
    logic           stop_smallfifo_read;
    logic [TBW-1:0] thread_sel;
    logic [TBW-1:0] thread_sel_next;
    logic [DW-1:0]  out_data;
    logic           firstword_out;
    logic           fifowrite_out;
    logic           out_last;
    logic           enable_cpu_out;
    logic           pkt_trunc;
    logic [15:0]    drop_cnt;

    always #5 clk = ~clk;

    infifo_thread_scheduler #(
        .NUM_THREADS(NT),
        .THREAD_BITS(TBW),
        .DATA_WIDTH(DW),
        .MAX_WORDS(MAXW),
        .SKIP_BUSY(SKIP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_fifo_empty(in_fifo_empty),
        .in_fifo_data(in_fifo_data),
        .in_fifo_sof(in_fifo_sof),
        .in_fifo_eof(in_fifo_eof),
        .in_fifo_rd_en(in_fifo_rd_en),
        .stop_smallfifo_read(stop_smallfifo_read),
        .thread_sel(thread_sel),
        .thread_sel_next(thread_sel_next),
        .out_data(out_data),
        .firstword_out(firstword_out),
        .fifowrite_out(fifowrite_out),
        .out_last(out_last),
        .enable_cpu_out(enable_cpu_out),
        .pkt_trunc(pkt_trunc),
        .drop_cnt(drop_cnt)
    );

    word_t fq[$];
    int total = 0;
    int bad   = 0;

    // reference model: packet progress, post-packet gap, thread bookkeeping
    bit            m_in_pkt;
    bit            m_trunc;
    int            m_gap;
    int            m_words;
    int            m_cand;
    int            m_owner;
    int            m_drops;
    bit            e_wr;
    bit            e_first;
    bit            e_last;
    bit            e_en;
    logic [DW-1:0] e_data;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_pkt = 0;
        m_trunc  = 0;
        m_gap    = 0;
        m_words  = 0;
        m_cand   = 0;
        m_owner  = 0;
        m_drops  = 0;
        e_wr     = 0;
        e_first  = 0;
        e_last   = 0;
        e_en     = 0;
        e_data   = '0;
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic add_packet(input int len, input int garbage);
        word_t w;
        for (int i = 0; i < garbage; i++) begin
            w = '{sof: 1'b0, eof: 1'b0, data: rnd64()};
            fq.push_back(w);
        end
        for (int i = 0; i < len; i++) begin
            w = '{sof: (i == 0), eof: (i == len - 1), data: rnd64()};
            fq.push_back(w);
        end
    endtask

    task automatic step(input bit rst, input int hole_pct, input int stop_pct);
        word_t hd;
        bit    hole;
        bit    p;
        hole = ($urandom_range(99) < hole_pct);
        if (fq.size() > 0)
            hd = fq[0];
        else
            hd = '{sof: 1'b0, eof: 1'b0, data: rnd64()};
        reset               = rst;
        in_fifo_empty       = (fq.size() == 0) || hole;
        in_fifo_sof         = hd.sof;
        in_fifo_eof         = hd.eof;
        in_fifo_data        = hd.data;
        stop_smallfifo_read = ($urandom_range(99) < stop_pct);
        #1;
        if (rst || m_gap > 0)
            p = 0;
        else if (m_in_pkt)
            p = !in_fifo_empty;
        else
            p = !in_fifo_empty && (!hd.sof || !stop_smallfifo_read);
        check("rd_en", {63'd0, in_fifo_rd_en}, {63'd0, p});
        @(posedge clk);
        e_wr    = 0;
        e_first = 0;
        e_last  = 0;
        e_en    = 0;
        if (rst) begin
            model_reset();
        end else if (m_gap > 0) begin
            if (m_gap == 2)
                e_en = 1;
            else
                m_cand = (m_owner + 1) % NT;
            m_gap--;
        end else if (m_in_pkt) begin
            if (p) begin
                e_wr   = 1;
                e_data = hd.data;
                m_words++;
                if (hd.eof || m_words == MAXW) begin
                    e_last   = 1;
                    m_in_pkt = 0;
                    m_gap    = 2;
                    if (!hd.eof)
                        m_trunc = 1;
                end
            end
        end else if (!in_fifo_empty) begin
            if (!hd.sof) begin
                if (m_drops < 65535)
                    m_drops++;
            end else if (stop_smallfifo_read) begin
                if (SKIP)
                    m_cand = (m_cand + 1) % NT;
            end else begin
                m_owner = m_cand;
                e_wr    = 1;
                e_first = 1;
                e_data  = hd.data;
                m_words = 1;
                if (hd.eof) begin
                    e_last = 1;
                    m_gap  = 2;
                end else begin
                    m_in_pkt = 1;
                end
            end
        end
        if (p)
            void'(fq.pop_front());
        @(negedge clk);
        check("fifowrite", {63'd0, fifowrite_out}, {63'd0, e_wr});
        check("firstword", {63'd0, firstword_out}, {63'd0, e_first});
        check("out_last", {63'd0, out_last}, {63'd0, e_last});
        check("enable_cpu", {63'd0, enable_cpu_out}, {63'd0, e_en});
        check("out_data", out_data, e_data);
        check("thread_sel", {62'd0, thread_sel}, 64'(m_owner));
        check("thread_sel_next", {62'd0, thread_sel_next}, 64'(m_cand));
        check("pkt_trunc", {63'd0, pkt_trunc}, {63'd0, m_trunc});
        check("drop_cnt", {48'd0, drop_cnt}, 64'(m_drops));
    endtask

    initial begin
        reset               = 1'b1;
        in_fifo_empty       = 1'b1;
        in_fifo_data        = '0;
        in_fifo_sof         = 1'b0;
        in_fifo_eof         = 1'b0;
        stop_smallfifo_read = 1'b0;
        model_reset();
        step(1, 0, 0);
        step(1, 0, 0);

        // four back-to-back single-word packets
        for (int i = 0; i < 4; i++)
            add_packet(1, 0);
        for (int i = 0; i < 14; i++)
            step(0, 0, 0);

        // busy candidate for two cycles, then free
        add_packet(2, 0);
        step(0, 0, 100);
        step(0, 0, 100);
        for (int i = 0; i < 8; i++)
            step(0, 0, 0);

        // truncated 6-word packet, then sof hunt and a follow-up packet
        add_packet(6, 0);
        add_packet(3, 3);
        for (int i = 0; i < 25; i++)
            step(0, 0, 0);

        // stalled 5-word packet, reset mid-packet
        add_packet(5, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 12; i++)
            step(0, 0, 0);

        // random traffic with holes, back-pressure and occasional reset
        for (int c = 0; c < 1500; c++) begin
            if (fq.size() < 4)
                add_packet($urandom_range(1, 6), $urandom_range(0, 2));
            step((c % 500) == 499, 25, 30);
        end
        for (int i = 0; i < 60; i++)
            step(0, 10, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
